tia_horizontal_decode: RTL and testbench



---
 rtl/tia_horizontal_decode_if.sv | 25 ++
 rtl/tia_horizontal_decode.sv | 103 ++++++++++
 tb/tb_tia_horizontal_decode.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/tia_horizontal_decode_if.sv
// Horizontal decode bus: LFSR sample inputs plus decoded timing outputs.
// The master side (LFSR/host) drives the tick, LFSR state and HMOVE strobe.
// The slave side (decoder) returns the registered horizontal timing signals.
interface tia_horizontal_decode_if;
    logic       hphi_en;
    logic [5:0] lfsr;
    logic       shb;
    logic       hmove;
    logic       hsync;
    logic       hblank;
    logic       cburst;
    logic       late_hblank;
    logic       motck_en;
    logic [7:0] hpos;

    modport master (
        output hphi_en, lfsr, shb, hmove,
        input  hsync, hblank, cburst, late_hblank, motck_en, hpos
    );

    modport slave (
        input  hphi_en, lfsr, shb, hmove,
        output hsync, hblank, cburst, late_hblank, motck_en, hpos
    );
endinterface

// File: rtl/tia_horizontal_decode.sv
// TIA horizontal decode: turns the sampled horizontal LFSR state into
// registered hsync / hblank / colour-burst / HMOVE-extension / motion-clock
// enable. Decoding happens only on hphi_en ticks; hmove is sampled every clk.
// Optional macro TIA_HPOS_COUNTER_EN builds an 8-bit saturating colour-clock
// position counter on hpos; without it hpos is tied to zero.
module tia_horizontal_decode #(
    parameter logic [5:0] SHS_PAT  = 6'b111100,
    parameter logic [5:0] RHS_PAT  = 6'b110111,
    parameter logic [5:0] RCB_PAT  = 6'b001111,
    parameter logic [5:0] RHB_PAT  = 6'b011100,
    parameter logic [5:0] LRHB_PAT = 6'b010111
) (
    input  logic                      clk,
    input  logic                      reset,
    tia_horizontal_decode_if.slave    bus
);

    logic hsync_p0, hblank_p0, cburst_p0, late_p0;
    logic hsync_p1, hblank_p1, cburst_p1, late_p1, motck_p1;

    // Stage p0: next-state decode. Pattern actions are applied in priority
    // order so that, with coinciding patterns, later actions override earlier.
    always_comb begin
        hsync_p0  = hsync_p1;
        hblank_p0 = hblank_p1;
        cburst_p0 = cburst_p1;
        late_p0   = late_p1;
        if (bus.hphi_en) begin
            if (bus.shb) begin
                hblank_p0 = 1'b1;
                hsync_p0  = 1'b0;
                cburst_p0 = 1'b0;
                late_p0   = 1'b0;
            end else begin
                if (bus.lfsr == SHS_PAT) begin
                    hsync_p0 = 1'b1;
                end
                if (bus.lfsr == RHS_PAT) begin
                    hsync_p0  = 1'b0;
                    cburst_p0 = 1'b1;
                end
                if (bus.lfsr == RCB_PAT) begin
                    cburst_p0 = 1'b0;
                end
                if (bus.lfsr == RHB_PAT && !late_p1) begin
                    hblank_p0 = 1'b0;
                end
                if (bus.lfsr == LRHB_PAT && late_p1) begin
                    hblank_p0 = 1'b0;
                end
            end
        end
        // HMOVE arms after the line-start clear, so a coincident strobe
        // carries into the new line.
        if (bus.hmove) begin
            late_p0 = 1'b1;
        end
    end

    // Stage p1: timing output registers; motck_en tracks the new hblank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hsync_p1  <= 1'b0;
            hblank_p1 <= 1'b1;
            cburst_p1 <= 1'b0;
            late_p1   <= 1'b0;
            motck_p1  <= 1'b0;
        end else begin
            hsync_p1  <= hsync_p0;
            hblank_p1 <= hblank_p0;
            cburst_p1 <= cburst_p0;
            late_p1   <= late_p0;
            motck_p1  <= ~hblank_p0;
        end
    end

    assign bus.hsync       = hsync_p1;
    assign bus.hblank      = hblank_p1;
    assign bus.cburst      = cburst_p1;
    assign bus.late_hblank = late_p1;
    assign bus.motck_en    = motck_p1;

`ifdef TIA_HPOS_COUNTER_EN
    logic [7:0] hpos_p1;

    // Position counter: restarts on a line-start tick, else counts every
    // clk and sticks at the top rather than wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hpos_p1 <= 8'h00;
        end else if (bus.hphi_en && bus.shb) begin
            hpos_p1 <= 8'h00;
        end else if (hpos_p1 != 8'hFF) begin
            hpos_p1 <= hpos_p1 + 8'h01;
        end
    end

    assign bus.hpos = hpos_p1;
`else
    assign bus.hpos = 8'h00;
`endif

endmodule

// File: tb/tb_tia_horizontal_decode.sv
// Directed bench for tia_horizontal_decode: reset, normal line, HMOVE line,
// coincident hmove/shb, gated ticks, illegal patterns, mid-line reset and
// (when TIA_HPOS_COUNTER_EN is defined) the position counter.
module tb_tia_horizontal_decode;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    tia_horizontal_decode_if bus();

    tia_horizontal_decode dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One hphi_en tick; returns 1 time unit after the closing edge.
    task automatic drive_tick(input logic [5:0] l, input logic s, input logic hm);
        @(negedge clk);
        bus.hphi_en = 1'b1;
        bus.lfsr    = l;
        bus.shb     = s;
        bus.hmove   = hm;
        @(posedge clk);
        #1;
        bus.hphi_en = 1'b0;
        bus.lfsr    = 6'd0;
        bus.shb     = 1'b0;
        bus.hmove   = 1'b0;
    endtask

    task automatic pulse_hmove();
        @(negedge clk);
        bus.hmove = 1'b1;
        @(posedge clk);
        #1;
        bus.hmove = 1'b0;
    endtask

    task automatic idle_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.hphi_en = 1'b0;
        bus.lfsr    = 6'd0;
        bus.shb     = 1'b0;
        bus.hmove   = 1'b0;

        // Reset with no clock edge yet
        #1 reset = 1'b1;
        #1;
        check_val("rst_hsync",  bus.hsync,       0);
        check_val("rst_hblank", bus.hblank,      1);
        check_val("rst_cburst", bus.cburst,      0);
        check_val("rst_late",   bus.late_hblank, 0);
        check_val("rst_motck",  bus.motck_en,    0);
        check_val("rst_hpos",   bus.hpos,        0);

        @(negedge clk);
        reset = 1'b0;
        idle_clk(3);
        check_val("hold_hblank", bus.hblank,   1);
        check_val("hold_motck",  bus.motck_en, 0);

        // Normal line
        drive_tick(6'b000000, 1'b1, 1'b0);
        check_val("n_shb_hblank", bus.hblank, 1);
        @(negedge clk);
        bus.hphi_en = 1'b1;
        bus.lfsr    = 6'b111100;
        #1;
        check_val("n_hs_pre", bus.hsync, 0);
        @(posedge clk);
        #1;
        bus.hphi_en = 1'b0;
        bus.lfsr    = 6'd0;
        check_val("n_hs_rise", bus.hsync, 1);
        drive_tick(6'b110111, 1'b0, 1'b0);
        check_val("n_hs_fall", bus.hsync,  0);
        check_val("n_cb_rise", bus.cburst, 1);
        drive_tick(6'b001111, 1'b0, 1'b0);
        check_val("n_cb_fall", bus.cburst, 0);
        check_val("n_hb_still", bus.hblank, 1);
        drive_tick(6'b011100, 1'b0, 1'b0);
        check_val("n_hb_fall", bus.hblank,      0);
        check_val("n_motck",   bus.motck_en,    1);
        check_val("n_late",    bus.late_hblank, 0);

        // HMOVE line
        drive_tick(6'b000000, 1'b1, 1'b0);
        check_val("h_shb_hblank", bus.hblank,   1);
        check_val("h_shb_motck",  bus.motck_en, 0);
        pulse_hmove();
        check_val("h_late_set", bus.late_hblank, 1);
        drive_tick(6'b011100, 1'b0, 1'b0);
        check_val("h_rhb_ignored", bus.hblank, 1);
        drive_tick(6'b010111, 1'b0, 1'b0);
        check_val("h_lrhb_hblank", bus.hblank,      0);
        check_val("h_lrhb_motck",  bus.motck_en,    1);
        check_val("h_late_hold",   bus.late_hblank, 1);
        drive_tick(6'b000000, 1'b1, 1'b0);
        check_val("h_late_clr",  bus.late_hblank, 0);
        check_val("h_hb_set",    bus.hblank,      1);

        // hmove coincident with shb
        drive_tick(6'b000000, 1'b1, 1'b1);
        check_val("s_late",   bus.late_hblank, 1);
        check_val("s_hblank", bus.hblank,      1);
        drive_tick(6'b011100, 1'b0, 1'b0);
        check_val("s_rhb_ignored", bus.hblank, 1);
        drive_tick(6'b010111, 1'b0, 1'b0);
        check_val("s_lrhb", bus.hblank, 0);

        // Patterns without hphi_en are ignored
        @(negedge clk);
        bus.lfsr = 6'b111100;
        bus.shb  = 1'b1;
        idle_clk(2);
        bus.lfsr = 6'b110111;
        bus.shb  = 1'b0;
        idle_clk(2);
        bus.lfsr = 6'd0;
        check_val("g_hblank", bus.hblank,      0);
        check_val("g_hsync",  bus.hsync,       0);
        check_val("g_cburst", bus.cburst,      0);
        check_val("g_late",   bus.late_hblank, 1);

        // Illegal all-zero pattern without shb
        drive_tick(6'b000000, 1'b0, 1'b0);
        check_val("z_hblank", bus.hblank,      0);
        check_val("z_late",   bus.late_hblank, 1);

        // Late hmove on a normal line affects only this line
        drive_tick(6'b000000, 1'b1, 1'b0);
        drive_tick(6'b011100, 1'b0, 1'b0);
        check_val("l_hb_fall", bus.hblank, 0);
        pulse_hmove();
        check_val("l_late",   bus.late_hblank, 1);
        check_val("l_hblank", bus.hblank,      0);
        drive_tick(6'b000000, 1'b1, 1'b0);
        check_val("l_late_clr", bus.late_hblank, 0);
        drive_tick(6'b011100, 1'b0, 1'b0);
        check_val("l_next_hb", bus.hblank, 0);

        // Mid-line reset
        drive_tick(6'b000000, 1'b1, 1'b0);
        drive_tick(6'b111100, 1'b0, 1'b0);
        check_val("m_hs_pre", bus.hsync, 1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_val("m_hsync",  bus.hsync,    0);
        check_val("m_hblank", bus.hblank,   1);
        check_val("m_motck",  bus.motck_en, 0);
        @(negedge clk);
        reset = 1'b0;
        drive_tick(6'b011100, 1'b0, 1'b0);
        check_val("m_hb_after", bus.hblank,   0);
        check_val("m_motck_after", bus.motck_en, 1);

`ifdef TIA_HPOS_COUNTER_EN
        drive_tick(6'b000000, 1'b1, 1'b0);
        check_val("p_load", bus.hpos, 0);
        idle_clk(10);
        check_val("p_ten", bus.hpos, 10);
        idle_clk(300);
        check_val("p_sat", bus.hpos, 255);
`else
        idle_clk(300);
        check_val("p_tied", bus.hpos, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
